move_unmaker: RTL and testbench

- History stack paired with the move-applying stage. The search/UI side pushes each move together with the board it is played on. On an undo request, the block pops the newest record and rebuilds the pre-move board from the current post-move board.
- Lets search/backtracking and UI "take back" restore a board without storing full board snapshots.
- Sits beside the executor; consumes the same move_t/board_t types.

---
 rtl/move_unmaker_if.sv | 62 ++++++
 rtl/move_unmaker.sv | 198 +++++++++++++++++++
 tb/tb_move_unmaker.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/move_unmaker_if.sv
// Shared move/board types and the push/undo handshake interface of the move unmaker.
package move_unmaker_pkg;
  typedef enum logic [2:0] {
    SPECIAL_UNKNOWN        = 3'd0,
    SPECIAL_NONE           = 3'd1,
    SPECIAL_CASTLE         = 3'd2,
    SPECIAL_EN_PASSANT     = 3'd3,
    SPECIAL_PROMOTE_KNIGHT = 3'd4,
    SPECIAL_PROMOTE_BISHOP = 3'd5,
    SPECIAL_PROMOTE_ROOK   = 3'd6,
    SPECIAL_PROMOTE_QUEEN  = 3'd7
  } special_t;

  // Bitboard slots; a capture kind below NUM_BB names the slot directly.
  localparam int BB_P = 0, BB_N = 1, BB_B = 2, BB_R = 3, BB_Q = 4, NUM_BB = 5;
  localparam logic [2:0] CAP_K    = 3'd5;
  localparam logic [2:0] CAP_NONE = 3'd7;

  typedef struct packed {
    logic [5:0] src;
    logic [5:0] dst;
    special_t   special;
  } move_t;

  typedef struct packed {
    logic [NUM_BB-1:0][63:0] bb;
    logic [1:0][5:0]         kings;      // [0] white, [1] black
    logic [63:0]             pieces_w;   // 1 = white piece (kings included)
    logic [3:0]              castle;
    logic [6:0]              en_passant; // [6] valid, [5:0] square
    logic [6:0]              ply50;
    logic [15:0]             ply;        // ply[0]==0: white to move
    logic                    checkmate;
  } board_t;
endpackage

interface move_unmaker_if
  import move_unmaker_pkg::*;
#(
  parameter int PW = 7
);
  logic          push_valid_in;
  move_t         push_move_in;
  board_t        push_board_in;
  logic          push_ready_out;
  logic          undo_valid_in;
  board_t        board_in;
  logic          undo_ready_out;
  board_t        board_out;
  logic          valid_out;
  logic [PW-1:0] depth_out;
  logic          error_out;

  modport master (
    output push_valid_in, push_move_in, push_board_in, undo_valid_in, board_in,
    input  push_ready_out, undo_ready_out, board_out, valid_out, depth_out, error_out
  );
  modport slave (
    input  push_valid_in, push_move_in, push_board_in, undo_valid_in, board_in,
    output push_ready_out, undo_ready_out, board_out, valid_out, depth_out, error_out
  );
endinterface

// File: rtl/move_unmaker.sv
// Move history stack: records moves on push, rebuilds the pre-move board on undo.
// Optional UNMAKER_PLY_CHECK_EN stores the ply and rejects undos with a mismatched board.
module move_unmaker
  import move_unmaker_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int PW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  move_unmaker_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, READ, BUILD} state_t;

  typedef struct packed {
    logic [5:0]  src;
    logic [5:0]  dst;
    special_t    special;
    logic [2:0]  cap_kind;
    logic [5:0]  cap_sq;
    logic        castle_mv;
    logic [3:0]  castle;
    logic [6:0]  en_passant;
    logic [6:0]  ply50;
    logic        checkmate;
`ifdef UNMAKER_PLY_CHECK_EN
    logic [15:0] ply;
`endif
  } rec_t;

  state_t        r_state, w_state_next;
  logic [PW-1:0] r_depth;
  rec_t          r_mem [DEPTH];
  rec_t          r_rec;
  board_t        r_board, r_board_out;
  logic          r_valid, r_error;

  board_t        w_pb, w_rebuilt;
  move_t         w_pm;
  rec_t          w_new_rec;
  logic [63:0]   w_occ;
  logic [2:0]    w_dx;
  logic [5:0]    w_rook_from, w_rook_to;
  logic [AW-1:0] w_wr_ptr, w_rd_ptr;
  logic          w_full, w_empty, w_push_ready, w_undo_ready, w_push_acc, w_undo_acc;
  logic          w_reject, w_ply_bad, w_src_pawn, w_src_king, w_ep, w_b, w_opp, w_unused_bits;

  assign w_pb         = bus.push_board_in;
  assign w_pm         = bus.push_move_in;
  assign w_full       = (r_depth == PW'(DEPTH));
  assign w_empty      = (r_depth == '0);
  assign w_push_ready = !rst_in && (r_state == IDLE) && !w_full;
  assign w_undo_ready = !rst_in && (r_state == IDLE) && !w_empty && !bus.push_valid_in;
  assign w_push_acc   = bus.push_valid_in && w_push_ready;
  assign w_undo_acc   = bus.undo_valid_in && w_undo_ready;
  assign w_reject     = (r_state == IDLE) && ((bus.push_valid_in && w_full) ||
                        (bus.undo_valid_in && w_empty && !bus.push_valid_in));
  assign w_wr_ptr     = r_depth[AW-1:0];
  assign w_rd_ptr     = w_wr_ptr - AW'(1);

  // Classify the capture against the pre-move board so undo needs no lookahead.
  always_comb begin
    w_occ = '0;
    for (int i = 0; i < NUM_BB; i++) w_occ = w_occ | w_pb.bb[i];
    w_occ[w_pb.kings[0]] = 1'b1;
    w_occ[w_pb.kings[1]] = 1'b1;
    w_dx = (w_pm.src[2:0] > w_pm.dst[2:0]) ? (w_pm.src[2:0] - w_pm.dst[2:0])
                                           : (w_pm.dst[2:0] - w_pm.src[2:0]);
    w_src_pawn = w_pb.bb[BB_P][w_pm.src];
    w_src_king = (w_pb.kings[0] == w_pm.src) || (w_pb.kings[1] == w_pm.src);
    w_ep = (w_pm.special == SPECIAL_EN_PASSANT) ||
           ((w_pm.special == SPECIAL_UNKNOWN) && w_src_pawn &&
            (w_pm.dst[2:0] != w_pm.src[2:0]) && !w_occ[w_pm.dst]);

    w_new_rec            = '0;
    w_new_rec.src        = w_pm.src;
    w_new_rec.dst        = w_pm.dst;
    w_new_rec.special    = w_pm.special;
    w_new_rec.cap_sq     = w_pm.dst;
    w_new_rec.cap_kind   = CAP_NONE;
    if (w_ep) begin
      w_new_rec.cap_kind = 3'(BB_P);
      w_new_rec.cap_sq   = w_pb.ply[0] ? (w_pm.dst + 6'd8) : (w_pm.dst - 6'd8);
    end else if ((w_pb.kings[0] == w_pm.dst) || (w_pb.kings[1] == w_pm.dst)) begin
      w_new_rec.cap_kind = CAP_K;
    end else begin
      for (int i = NUM_BB - 1; i >= 0; i--)
        if (w_pb.bb[i][w_pm.dst]) w_new_rec.cap_kind = 3'(i);
    end
    w_new_rec.castle_mv  = w_src_king && ((w_pm.special == SPECIAL_CASTLE) ||
                           ((w_pm.special == SPECIAL_UNKNOWN) && (w_dx > 3'd1)));
    w_new_rec.castle     = w_pb.castle;
    w_new_rec.en_passant = w_pb.en_passant;
    w_new_rec.ply50      = w_pb.ply50;
    w_new_rec.checkmate  = w_pb.checkmate;
`ifdef UNMAKER_PLY_CHECK_EN
    w_new_rec.ply        = w_pb.ply;
`endif
  end

  assign w_b         = ~r_board.ply[0];
  assign w_opp       = ~w_b;
  assign w_rook_from = {r_rec.src[5:3], (r_rec.dst < r_rec.src) ? 3'd3 : 3'd5};
  assign w_rook_to   = {r_rec.src[5:3], (r_rec.dst < r_rec.src) ? 3'd0 : 3'd7};

  always_comb begin
    w_rebuilt = r_board;
    if (r_board.kings[w_b] == r_rec.dst) begin
      w_rebuilt.kings[w_b] = r_rec.src;
    end else if (r_rec.special >= SPECIAL_PROMOTE_KNIGHT) begin
      for (int i = 0; i < NUM_BB; i++) w_rebuilt.bb[i][r_rec.dst] = 1'b0;
      w_rebuilt.bb[BB_P][r_rec.src] = 1'b1;
    end else begin
      for (int i = 0; i < NUM_BB; i++)
        if (r_board.bb[i][r_rec.dst]) begin
          w_rebuilt.bb[i][r_rec.dst] = 1'b0;
          w_rebuilt.bb[i][r_rec.src] = 1'b1;
        end
    end
    w_rebuilt.pieces_w[r_rec.dst] = 1'b0;
    w_rebuilt.pieces_w[r_rec.src] = ~w_b;
    for (int i = 0; i < NUM_BB; i++)
      if (r_rec.cap_kind == 3'(i)) w_rebuilt.bb[i][r_rec.cap_sq] = 1'b1;
    if (r_rec.cap_kind == CAP_K) w_rebuilt.kings[w_opp] = r_rec.cap_sq;
    if (r_rec.cap_kind != CAP_NONE) w_rebuilt.pieces_w[r_rec.cap_sq] = w_b;
    if (r_rec.castle_mv) begin
      w_rebuilt.bb[BB_R][w_rook_from] = 1'b0;
      w_rebuilt.bb[BB_R][w_rook_to]   = 1'b1;
      w_rebuilt.pieces_w[w_rook_from] = 1'b0;
      w_rebuilt.pieces_w[w_rook_to]   = ~w_b;
    end
    w_rebuilt.castle     = r_rec.castle;
    w_rebuilt.en_passant = r_rec.en_passant;
    w_rebuilt.ply50      = r_rec.ply50;
    w_rebuilt.checkmate  = r_rec.checkmate;
    w_rebuilt.ply        = r_board.ply - 16'd1;
  end

`ifdef UNMAKER_PLY_CHECK_EN
  assign w_ply_bad     = (r_board.ply != (r_rec.ply + 16'd1));
  assign w_unused_bits = ^{w_pb.pieces_w, r_board.castle, r_board.en_passant,
                           r_board.ply50, r_board.checkmate};
`else
  assign w_ply_bad     = 1'b0;
  assign w_unused_bits = ^{w_pb.pieces_w, w_pb.ply[15:1], r_board.castle,
                           r_board.en_passant, r_board.ply50, r_board.checkmate};
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_undo_acc) w_state_next = READ;
      READ:    w_state_next = BUILD;
      BUILD:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= IDLE;
      r_depth     <= '0;
      r_valid     <= 1'b0;
      r_error     <= 1'b0;
      r_board_out <= '0;
    end else begin
      r_state <= w_state_next;
      r_valid <= 1'b0;
      r_error <= w_reject;
      if (w_push_acc)             r_depth <= r_depth + PW'(1);
      else if (r_state == READ)   r_depth <= r_depth - PW'(1);
      if (r_state == BUILD) begin
        if (w_ply_bad) begin
          r_error <= 1'b1;
        end else begin
          r_valid     <= 1'b1;
          r_board_out <= w_rebuilt;
        end
      end
    end
  end

  // Record storage and its registered read port; contents need no reset.
  always_ff @(posedge clk_in) begin
    if (w_push_acc)        r_mem[w_wr_ptr] <= w_new_rec;
    if (r_state == READ)   r_rec <= r_mem[w_rd_ptr];
    if (w_undo_acc)        r_board <= bus.board_in;
  end

  assign bus.push_ready_out = w_push_ready;
  assign bus.undo_ready_out = w_undo_ready;
  assign bus.board_out      = r_board_out;
  assign bus.valid_out      = r_valid;
  assign bus.depth_out      = r_depth;
  assign bus.error_out      = r_error;
endmodule

// File: tb/tb_move_unmaker.sv
// Scoreboard bench for move_unmaker: hand-built pre/post boards, undo must return the pre board.
module tb_move_unmaker;
  import move_unmaker_pkg::*;

  localparam int DEPTH = 8;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  move_unmaker_if #(.PW(PW)) bus ();
  move_unmaker #(.DEPTH(DEPTH), .PW(PW)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));

  int     n_checks = 0;
  int     n_fail   = 0;
  int     n_valid  = 0;
  int     n_err    = 0;
  board_t sb_q[$];
  board_t pre_b[6];
  board_t post_b[6];
  move_t  mv[6];

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] bit_at(input int sq);
    return 64'd1 << sq;
  endfunction

  function automatic board_t blank(input int wk, input int bk, input int ply);
    board_t b;
    b          = '0;
    b.kings[0] = 6'(wk);
    b.kings[1] = 6'(bk);
    b.pieces_w = bit_at(wk);
    b.ply      = 16'(ply);
    return b;
  endfunction

  function automatic move_t mk(input int s, input int d, input special_t sp);
    move_t m;
    m.src = 6'(s); m.dst = 6'(d); m.special = sp;
    return m;
  endfunction

  // Output side of the scoreboard.
  always @(negedge clk) begin
    if (bus.error_out) n_err++;
    if (bus.valid_out) begin
      n_valid++;
      if (sb_q.size() == 0) begin
        chk("valid_without_expect", bus.valid_out, 1'b0);
      end else begin
        board_t e;
        e = sb_q.pop_front();
        chk("board_out", bus.board_out, e);
        $display("undo result #%0d depth=%0d ply=%0d", n_valid, bus.depth_out, bus.board_out.ply);
      end
    end
  end

  task automatic do_push(input move_t m, input board_t b);
    int n;
    bus.push_valid_in = 1'b1;
    bus.push_move_in  = m;
    bus.push_board_in = b;
    #1;
    n = 0;
    while (!bus.push_ready_out && n < 20) begin @(negedge clk); n++; end
    chk("push_ready", bus.push_ready_out, 1'b1);
    @(negedge clk);
    bus.push_valid_in = 1'b0;
    $display("push src=%0d dst=%0d depth=%0d", m.src, m.dst, bus.depth_out);
  endtask

  task automatic do_undo(input board_t post, input board_t exp);
    int n;
    bus.undo_valid_in = 1'b1;
    bus.board_in      = post;
    sb_q.push_back(exp);
    #1;
    n = 0;
    while (!bus.undo_ready_out && n < 20) begin @(negedge clk); n++; end
    chk("undo_ready", bus.undo_ready_out, 1'b1);
    @(negedge clk);
    bus.undo_valid_in = 1'b0;
    n = 1;
    while (!bus.valid_out && n < 10) begin @(negedge clk); n++; end
    chk("undo_latency", n, 3);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    board_t b, p;
    int e0, v0, n;

    // 0: e2e4 from the start position
    b = blank(4, 60, 0);
    b.bb[BB_P] = 64'h00FF_0000_0000_FF00;
    b.bb[BB_N] = 64'h4200_0000_0000_0042;
    b.bb[BB_B] = 64'h2400_0000_0000_0024;
    b.bb[BB_R] = 64'h8100_0000_0000_0081;
    b.bb[BB_Q] = 64'h0800_0000_0000_0008;
    b.pieces_w = 64'h0000_0000_0000_FFFF;
    b.castle   = 4'b1111;
    pre_b[0] = b; mv[0] = mk(12, 28, SPECIAL_UNKNOWN);
    p = b; p.bb[BB_P][12] = 1'b0; p.bb[BB_P][28] = 1'b1;
    p.pieces_w[12] = 1'b0; p.pieces_w[28] = 1'b1;
    p.en_passant = 7'h40 | 7'd20; p.ply = 16'd1;
    post_b[0] = p;
    // 1: white Bc4xf7 taking a black pawn
    b = blank(4, 60, 0);
    b.bb[BB_B] = bit_at(26); b.bb[BB_P] = bit_at(53); b.pieces_w |= bit_at(26); b.ply50 = 7'd5;
    pre_b[1] = b; mv[1] = mk(26, 53, SPECIAL_NONE);
    p = b; p.bb[BB_B][26] = 1'b0; p.bb[BB_B][53] = 1'b1; p.bb[BB_P][53] = 1'b0;
    p.pieces_w[26] = 1'b0; p.pieces_w[53] = 1'b1; p.ply50 = 7'd0; p.ply = 16'd1;
    post_b[1] = p;
    // 2: white short castle e1g1
    b = blank(4, 60, 0);
    b.bb[BB_R] = bit_at(0) | bit_at(7); b.pieces_w |= bit_at(0) | bit_at(7); b.castle = 4'b1111;
    pre_b[2] = b; mv[2] = mk(4, 6, SPECIAL_UNKNOWN);
    p = b; p.kings[0] = 6'd6; p.bb[BB_R][7] = 1'b0; p.bb[BB_R][5] = 1'b1;
    p.pieces_w[4] = 1'b0; p.pieces_w[6] = 1'b1; p.pieces_w[7] = 1'b0; p.pieces_w[5] = 1'b1;
    p.castle = 4'b1100; p.ply = 16'd1;
    post_b[2] = p;
    // 3: white en passant e5xd6
    b = blank(4, 60, 2);
    b.bb[BB_P] = bit_at(36) | bit_at(35); b.pieces_w |= bit_at(36); b.en_passant = 7'h40 | 7'd43;
    pre_b[3] = b; mv[3] = mk(36, 43, SPECIAL_UNKNOWN);
    p = b; p.bb[BB_P][36] = 1'b0; p.bb[BB_P][43] = 1'b1; p.bb[BB_P][35] = 1'b0;
    p.pieces_w[36] = 1'b0; p.pieces_w[43] = 1'b1; p.en_passant = 7'd0; p.ply = 16'd3;
    post_b[3] = p;
    // 4: white promotion e7e8=Q
    b = blank(4, 40, 4);
    b.bb[BB_P] = bit_at(52); b.pieces_w |= bit_at(52);
    pre_b[4] = b; mv[4] = mk(52, 60, SPECIAL_PROMOTE_QUEEN);
    p = b; p.bb[BB_P][52] = 1'b0; p.bb[BB_Q][60] = 1'b1;
    p.pieces_w[52] = 1'b0; p.pieces_w[60] = 1'b1; p.ply = 16'd5;
    post_b[4] = p;
    // 5: black Nb8xc6 taking a white queen
    b = blank(4, 60, 7);
    b.bb[BB_N] = bit_at(57); b.bb[BB_Q] = bit_at(42); b.pieces_w |= bit_at(42);
    b.ply50 = 7'd9; b.castle = 4'b0011;
    pre_b[5] = b; mv[5] = mk(57, 42, SPECIAL_NONE);
    p = b; p.bb[BB_N][57] = 1'b0; p.bb[BB_N][42] = 1'b1; p.bb[BB_Q][42] = 1'b0;
    p.pieces_w[42] = 1'b0; p.ply50 = 7'd0; p.ply = 16'd8;
    post_b[5] = p;

    bus.push_valid_in = 1'b0; bus.push_move_in = '0; bus.push_board_in = '0;
    bus.undo_valid_in = 1'b0; bus.board_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_depth", bus.depth_out, 0);
    chk("rst_valid", bus.valid_out, 1'b0);
    chk("rst_error", bus.error_out, 1'b0);
    chk("rst_board_out", bus.board_out, 0);
    chk("rst_push_ready", bus.push_ready_out, 1'b0);
    chk("rst_undo_ready", bus.undo_ready_out, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_push_ready", bus.push_ready_out, 1'b1);

    // Undo on an empty stack
    bus.undo_valid_in = 1'b1;
    #1 chk("empty_undo_ready", bus.undo_ready_out, 1'b0);
    @(negedge clk);
    bus.undo_valid_in = 1'b0;
    chk("empty_undo_error", bus.error_out, 1'b1);
    @(negedge clk);
    chk("error_one_cycle", bus.error_out, 1'b0);
    chk("empty_depth", bus.depth_out, 0);

    for (int i = 0; i < 6; i++) begin
      do_push(mv[i], pre_b[i]);
      chk("push_depth", bus.depth_out, i + 1);
    end
    for (int i = 5; i >= 0; i--) begin
      do_undo(post_b[i], pre_b[i]);
      chk("undo_depth", bus.depth_out, i);
    end

    // Push and undo in the same cycle: push only
    do_push(mv[0], pre_b[0]);
    e0 = n_err; v0 = n_valid;
    bus.undo_valid_in = 1'b1; bus.board_in = post_b[1];
    do_push(mv[1], pre_b[1]);
    bus.undo_valid_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("both_depth", bus.depth_out, 2);
    chk("both_no_error", n_err, e0);
    chk("both_no_valid", n_valid, v0);
    do_undo(post_b[1], pre_b[1]);
    chk("both_undo1_depth", bus.depth_out, 1);
    do_undo(post_b[0], pre_b[0]);
    chk("both_undo2_depth", bus.depth_out, 0);

    // Fill, then overflow
    for (int i = 0; i < DEPTH; i++) do_push(mv[0], pre_b[0]);
    chk("full_depth", bus.depth_out, DEPTH);
    bus.push_valid_in = 1'b1;
    #1 chk("full_push_ready", bus.push_ready_out, 1'b0);
    @(negedge clk);
    bus.push_valid_in = 1'b0;
    chk("full_push_error", bus.error_out, 1'b1);
    @(negedge clk);
    chk("full_error_one_cycle", bus.error_out, 1'b0);
    chk("full_depth_kept", bus.depth_out, DEPTH);

    // Reset while the undo is in READ
    v0 = n_valid;
    bus.undo_valid_in = 1'b1; bus.board_in = post_b[0];
    #1;
    n = 0;
    while (!bus.undo_ready_out && n < 20) begin @(negedge clk); n++; end
    chk("rst_read_undo_ready", bus.undo_ready_out, 1'b1);
    @(negedge clk);
    bus.undo_valid_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_read_no_valid", n_valid, v0);
    chk("rst_read_depth", bus.depth_out, 0);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
